muldiv32: RTL and testbench

MULDIV32 -- requirements
Module: muldiv32

---
 rtl/muldiv32.sv | 184 ++++++++++++++++++
 tb/tb_muldiv32.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv32.sv
// Iterative 32-bit multiply/divide unit: radix-2 shift-add multiply, restoring divide, 32 steps per op.
// Define MULDIV_SIGNED_EN to make op=00/10 signed mult/div; otherwise they alias multu/divu.
module muldiv32 (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic [31:0] hi_from_ALU,
    output logic [31:0] lo_from_ALU,
    output logic [3:0]  dbg_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    // start is honoured when state is IDLE or DONE; ignored while RUN.
    // Control state and the latched op are exposed on dbg_o as {op_q, state_q}.
    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] mag_q, mag_d;
    logic [31:0] acc_hi_q, acc_hi_d;
    logic [31:0] acc_lo_q, acc_lo_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        dbz_q, dbz_d;
`ifdef MULDIV_SIGNED_EN
    logic        neg_q, neg_d;
    logic        neg_rem_q, neg_rem_d;
    logic        a_neg, b_neg;
`endif

    logic        accept;
    logic        is_div;
    logic [31:0] a_mag, b_mag;
    logic [32:0] sum;
    logic [32:0] rem_sh;
    logic [32:0] diff;
    logic [31:0] step_hi, step_lo;
    logic [31:0] fin_hi, fin_lo;

    always_comb begin
        accept = start && (state_q != RUN);
        is_div = op_q[1];

`ifdef MULDIV_SIGNED_EN
        a_neg = ~op[0] & operand_a[31];
        b_neg = ~op[0] & operand_b[31];
        a_mag = a_neg ? -operand_a : operand_a;
        b_mag = b_neg ? -operand_b : operand_b;
`else
        a_mag = operand_a;
        b_mag = operand_b;
`endif

        // acc_lo holds the multiplier (shifted out at the bottom) or the dividend (shifted out at the top)
        sum     = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mag_q} : 33'd0);
        rem_sh  = {acc_hi_q, acc_lo_q[31]};
        diff    = rem_sh - {1'b0, mag_q};
        if (is_div) begin
            step_hi = diff[32] ? rem_sh[31:0] : diff[31:0];
            step_lo = {acc_lo_q[30:0], ~diff[32]};
        end else begin
            step_hi = sum[32:1];
            step_lo = {sum[0], acc_lo_q[31:1]};
        end

        fin_hi = step_hi;
        fin_lo = step_lo;
`ifdef MULDIV_SIGNED_EN
        if (is_div) begin
            if (neg_q)     fin_lo = -step_lo;
            if (neg_rem_q) fin_hi = -step_hi;
        end else if (neg_q) begin
            {fin_hi, fin_lo} = -{step_hi, step_lo};
        end
`endif

        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        mag_d    = mag_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dbz_d    = 1'b0;
`ifdef MULDIV_SIGNED_EN
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
`endif

        case (state_q)
            RUN: begin
                if (is_div && (mag_q == 32'd0)) begin
                    state_d = DONE;
                    hi_d    = a_q;
                    lo_d    = 32'hFFFF_FFFF;
                    dbz_d   = 1'b1;
                end else begin
                    acc_hi_d = step_hi;
                    acc_lo_d = step_lo;
                    cnt_d    = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d = DONE;
                        hi_d    = fin_hi;
                        lo_d    = fin_lo;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (accept) begin
            state_d  = RUN;
            cnt_d    = 5'd0;
            op_d     = op;
            a_d      = operand_a;
            acc_hi_d = 32'd0;
            acc_lo_d = op[1] ? a_mag : b_mag;
            mag_d    = op[1] ? b_mag : a_mag;
`ifdef MULDIV_SIGNED_EN
            neg_d     = a_neg ^ b_neg;
            neg_rem_d = a_neg;
`endif
        end

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= 5'd0;
            op_q     <= 2'd0;
            a_q      <= 32'd0;
            mag_q    <= 32'd0;
            acc_hi_q <= 32'd0;
            acc_lo_q <= 32'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            mag_q    <= mag_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
`ifdef MULDIV_SIGNED_EN
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
`endif
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi_from_ALU = hi_q;
    assign lo_from_ALU = lo_q;
    assign dbg_o       = {op_q, state_q};
endmodule

// File: tb/tb_muldiv32.sv
// Directed-vector bench for muldiv32; expectations follow MULDIV_SIGNED_EN when it is defined.
module tb_muldiv32;
  logic        clock;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi_from_ALU;
  logic [31:0] lo_from_ALU;
  logic [3:0]  dbg_o;

  int n_vec;
  int n_miss;

  muldiv32 dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b),
    .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi_from_ALU(hi_from_ALU), .lo_from_ALU(lo_from_ALU), .dbg_o(dbg_o)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op = o;
    operand_a = a;
    operand_b = b;
    tick();
    start = 1'b0;
    op = 2'($urandom_range(0, 3));
    operand_a = $urandom;
    operand_b = $urandom;
  endtask

  // Waits for done (bounded); returns cycles after accept edge and busy-high samples before done.
  task automatic wait_done(output int cyc, output int busy_n);
    cyc = 0;
    busy_n = 0;
    while (!done && cyc < 40) begin
      if (busy) busy_n++;
      tick();
      cyc++;
    end
  endtask

  task automatic check_result(input string tag, input int exp_cyc, input logic [31:0] exp_hi,
                              input logic [31:0] exp_lo, input logic exp_dbz);
    int cyc, busy_n;
    wait_done(cyc, busy_n);
    check({tag, ".cycles"}, 32'(cyc), 32'(exp_cyc));
    check({tag, ".busy_cycles"}, 32'(busy_n), 32'(exp_cyc));
    check({tag, ".busy_at_done"}, {31'd0, busy}, 32'd0);
    check({tag, ".hi"}, hi_from_ALU, exp_hi);
    check({tag, ".lo"}, lo_from_ALU, exp_lo);
    check({tag, ".dbz"}, {31'd0, div_by_zero}, {31'd0, exp_dbz});
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int exp_cyc, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input logic exp_dbz);
    launch(o, a, b);
    check_result(tag, exp_cyc, exp_hi, exp_lo, exp_dbz);
    tick();
    check({tag, ".done_after"}, {31'd0, done}, 32'd0);
    check({tag, ".dbz_after"}, {31'd0, div_by_zero}, 32'd0);
    check({tag, ".hi_hold"}, hi_from_ALU, exp_hi);
    check({tag, ".state_idle"}, {30'd0, dbg_o[1:0]}, 32'd0);
  endtask

  initial begin
    int done_n;
    n_vec = 0;
    n_miss = 0;
    reset = 1'b0;
    start = 1'b0;
    op = 2'd0;
    operand_a = 32'd0;
    operand_b = 32'd0;
    repeat (3) tick();
    check("rst.busy", {31'd0, busy}, 32'd0);
    check("rst.done", {31'd0, done}, 32'd0);
    check("rst.dbz", {31'd0, div_by_zero}, 32'd0);
    check("rst.hi", hi_from_ALU, 32'd0);
    check("rst.lo", lo_from_ALU, 32'd0);
    reset = 1'b1;
    repeat (2) tick();
    check("idle.busy", {31'd0, busy}, 32'd0);

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
`ifdef MULDIV_SIGNED_EN
    run_op("mult_neg3x5", 2'b00, 32'hFFFF_FFFD, 32'd5, 32, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    run_op("mult_m1xm1", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32, 32'h0000_0000, 32'h0000_0001, 1'b0);
    run_op("div_m7d2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("div_minovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32, 32'h0000_0000, 32'h8000_0000, 1'b0);
`else
    run_op("mult_neg3x5", 2'b00, 32'hFFFF_FFFD, 32'd5, 32, 32'h0000_0004, 32'hFFFF_FFF1, 1'b0);
    run_op("mult_m1xm1", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("div_m7d2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32, 32'h0000_0001, 32'h7FFF_FFFC, 1'b0);
    run_op("div_minovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32, 32'h8000_0000, 32'h0000_0000, 1'b0);
`endif
    run_op("multu_7x6", 2'b01, 32'd7, 32'd6, 32, 32'd0, 32'd42, 1'b0);
    run_op("divu_100d7", 2'b11, 32'd100, 32'd7, 32, 32'd2, 32'd14, 1'b0);
    run_op("divu_by0", 2'b11, 32'h1234_5678, 32'd0, 1, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1);
    run_op("div_by0", 2'b10, 32'hFFFF_FFF0, 32'd0, 1, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1);

    // start pulses inside RUN are ignored
    launch(2'b01, 32'd3, 32'd4);
    done_n = 0;
    for (int c = 1; c <= 60; c++) begin
      if (c == 5 || c == 20) begin
        start = 1'b1;
        op = 2'b11;
        operand_a = 32'd100;
        operand_b = 32'd7;
      end else begin
        start = 1'b0;
      end
      tick();
      if (done) begin
        done_n++;
        check("ign.cycle", 32'(c), 32'd32);
        check("ign.hi", hi_from_ALU, 32'd0);
        check("ign.lo", lo_from_ALU, 32'd12);
      end
    end
    check("ign.done_count", 32'(done_n), 32'd1);

    // start held through DONE launches a second RUN immediately
    launch(2'b11, 32'd100, 32'd7);
    check_result("b2b1", 32, 32'd2, 32'd14, 1'b0);
    start = 1'b1;
    op = 2'b01;
    operand_a = 32'h0001_0000;
    operand_b = 32'h0001_0000;
    tick();
    start = 1'b0;
    check("b2b.busy", {31'd0, busy}, 32'd1);
    check("b2b.done", {31'd0, done}, 32'd0);
    check("b2b.hi_hold", hi_from_ALU, 32'd2);
    check("b2b.lo_hold", lo_from_ALU, 32'd14);
    check_result("b2b2", 32, 32'd1, 32'd0, 1'b0);
    tick();

    // reset in the middle of a RUN
    launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (9) tick();
    check("mid.busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    check("mid.busy", {31'd0, busy}, 32'd0);
    check("mid.hi", hi_from_ALU, 32'd0);
    check("mid.lo", lo_from_ALU, 32'd0);
    check("mid.done", {31'd0, done}, 32'd0);
    repeat (2) tick();
    reset = 1'b1;
    done_n = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (done || busy) done_n++;
    end
    check("mid.no_activity", 32'(done_n), 32'd0);
    check("mid.state_idle", {30'd0, dbg_o[1:0]}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
